// File: rtl/spi_master.sv
// SPI mode-0 initiator: one 16-bit {addr, rw, data} frame per start, MSB first.
// Optional build macro SPI_MISO_SYNC_EN adds a 2-flop miso synchronizer and a later sample point.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [4:0]  bit_q;
  logic [15:0] tx_q;
  logic [7:0]  rx_q;
  logic [7:0]  rdata_q;
  logic        rw_q, sclk_q, cs_q, mosi_q, busy_q, done_q;
  logic        cnt_last, sample_d, miso_d;

  assign cnt_last = (cnt_q == DIV_LAST);

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], miso_pin};
  end
  // Two cycles of synchronizer delay: the first low-phase cycle sees the value present late in the high phase.
  assign miso_d   = sync_q[1];
  assign sample_d = (state_q == SHIFT) && !sclk_q && (cnt_q == 8'd0);
`else
  assign miso_d   = miso_pin;
  assign sample_d = (state_q == SHIFT) && sclk_q && cnt_last;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 5'd0;
      tx_q    <= 16'h0000;
      rx_q    <= 8'h00;
      rdata_q <= 8'h00;
      rw_q    <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (sample_d) rx_q <= {rx_q[6:0], miso_d};
      case (state_q)
        IDLE: if (start) begin
          tx_q    <= {addr, rw, rw ? 8'h00 : wdata};
          rw_q    <= rw;
          cs_q    <= 1'b0;
          mosi_q  <= addr[6];
          busy_q  <= 1'b1;
          cnt_q   <= 8'd0;
          bit_q   <= 5'd0;
          state_q <= SETUP;
        end
        SETUP: begin
          if (cnt_last) begin
            cnt_q   <= 8'd0;
            sclk_q  <= 1'b1;
            state_q <= SHIFT;
          end else cnt_q <= cnt_q + 8'd1;
        end
        SHIFT: begin
          if (cnt_last) begin
            cnt_q <= 8'd0;
            if (sclk_q) begin
              // Falling edge: advance mosi; zero fill leaves mosi low after bit 0.
              sclk_q <= 1'b0;
              mosi_q <= tx_q[14];
              tx_q   <= {tx_q[14:0], 1'b0};
            end else begin
              bit_q <= bit_q + 5'd1;
              if (bit_q == 5'd15) begin
                mosi_q  <= 1'b0;
                state_q <= HOLD;
              end else sclk_q <= 1'b1;
            end
          end else cnt_q <= cnt_q + 8'd1;
        end
        HOLD: begin
          if (cnt_last) begin
            cnt_q   <= 8'd0;
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
            if (rw_q) rdata_q <= rx_q;
          end else cnt_q <= cnt_q + 8'd1;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sclk_pin = sclk_q;
  assign cs_pin   = cs_q;
  assign mosi_pin = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: pin-level slave model plus frame-level reference expectations.
module tb_spi_master;
`ifdef SPI_MISO_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 4;
`endif
  localparam int LAT = 34 * D + 1;

  logic       clk = 1'b0, reset = 1'b0, start = 1'b0, rw = 1'b0, miso_pin = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy, done, sclk_pin, cs_pin, mosi_pin;

  int n_chk = 0, n_fail = 0;

  spi_master #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .rw(rw), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
    .mosi_pin(mosi_pin), .miso_pin(miso_pin)
  );

  always #5 clk = ~clk;

  // Slave model: mode 0, presents bit k before the k-th rising sclk edge; returns rbyte on bits 8..15.
  logic [7:0]  cur_rbyte = 8'h00;
  logic [15:0] mosi_cap = 16'h0;
  int          rise_cnt = 0, cs_low = 0, glitch = 0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;

  function automatic logic slave_bit(input int k, input logic [7:0] rb);
    if (k >= 8 && k < 16) return rb[15-k];
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    if (!cs_pin && prev_cs) begin
      rise_cnt = 0; cs_low = 0; glitch = 0; mosi_cap = 16'h0;
      miso_pin = slave_bit(0, cur_rbyte);
    end else if (!cs_pin && mosi_pin !== prev_mosi && !(prev_sclk && !sclk_pin))
      glitch++;
    if (!cs_pin) cs_low++;
    if (sclk_pin && !prev_sclk) begin
      mosi_cap = {mosi_cap[14:0], mosi_pin};
      rise_cnt++;
    end
    if (!sclk_pin && prev_sclk) miso_pin = slave_bit(rise_cnt, cur_rbyte);
    prev_sclk = sclk_pin; prev_cs = cs_pin; prev_mosi = mosi_pin;
  end

  logic [7:0] exp_rdata = 8'h00;

  // Issues one request and returns the cycle count until done (2000 = timed out).
  task automatic run_frame(input logic [6:0] a, input logic r, input logic [7:0] w,
                           input logic [7:0] rb, output int lat);
    cur_rbyte = rb;
    @(negedge clk);
    addr = a; rw = r; wdata = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    addr = 7'($urandom); rw = 1'($urandom); wdata = 8'($urandom);
    lat = 1;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (cs_pin !== 1'b1)   begin n_fail++; $display("FAIL reset_cs got %b want 1", cs_pin); end
    n_chk++; if (sclk_pin !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b want 0", sclk_pin); end
    n_chk++; if (mosi_pin !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got %b want 0", mosi_pin); end
    n_chk++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_chk++; if (rdata !== 8'h00)   begin n_fail++; $display("FAIL reset_rdata got %h want 00", rdata); end
    reset = 1'b0;
    exp_rdata = 8'h00;
  endtask

  task automatic test_write;
    int lat;
    run_frame(7'h15, 1'b0, 8'hA5, 8'hFF, lat);
    n_chk++; if (lat != LAT)          begin n_fail++; $display("FAIL wr_latency got %0d want %0d", lat, LAT); end
    n_chk++; if (mosi_cap !== 16'h2AA5) begin n_fail++; $display("FAIL wr_mosi got %h want 2aa5", mosi_cap); end
    n_chk++; if (rise_cnt != 16)      begin n_fail++; $display("FAIL wr_sclk_edges got %0d want 16", rise_cnt); end
    n_chk++; if (cs_low != 34 * D)    begin n_fail++; $display("FAIL wr_cs_low got %0d want %0d", cs_low, 34 * D); end
    n_chk++; if (glitch != 0)         begin n_fail++; $display("FAIL wr_mosi_timing got %0d want 0", glitch); end
    n_chk++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL wr_rdata got %h want %h", rdata, exp_rdata); end
    n_chk++; if (busy !== 1'b1 || cs_pin !== 1'b1) begin n_fail++; $display("FAIL wr_done_cycle busy=%b cs=%b want 1 1", busy, cs_pin); end
    @(negedge clk);
    n_chk++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL wr_after_done done,busy=%b want 00", {done, busy}); end
  endtask

  task automatic test_read;
    int lat;
    run_frame(7'h03, 1'b1, 8'h77, 8'h3C, lat);
    exp_rdata = 8'h3C;
    n_chk++; if (lat != LAT)          begin n_fail++; $display("FAIL rd_latency got %0d want %0d", lat, LAT); end
    n_chk++; if (mosi_cap !== 16'h0700) begin n_fail++; $display("FAIL rd_mosi got %h want 0700", mosi_cap); end
    n_chk++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL rd_rdata got %h want %h", rdata, exp_rdata); end
  endtask

  task automatic test_busy_ignore;
    int n, dones, first, cs_after;
    logic [15:0] cap;
    cur_rbyte = 8'h00;
    @(negedge clk);
    addr = 7'h2B; rw = 1'b0; wdata = 8'h5E; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; first = 0; cs_after = 0; cap = 16'h0;
    for (n = 1; n < 2 * LAT + 20; n++) begin
      if (done) begin dones++; if (first == 0) begin first = n; cap = mosi_cap; end end
      else if (first != 0 && !cs_pin) cs_after++;
      if (n == 10 || n == 60) begin
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid cycle %0d got %b want 1", n, busy); end
        addr = 7'h7F; rw = 1'b1; wdata = 8'h00; start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    n_chk++; if (dones != 1)   begin n_fail++; $display("FAIL busy_done_count got %0d want 1", dones); end
    n_chk++; if (first != LAT) begin n_fail++; $display("FAIL busy_latency got %0d want %0d", first, LAT); end
    n_chk++; if (cap !== {7'h2B, 1'b0, 8'h5E}) begin n_fail++; $display("FAIL busy_mosi got %h want %h", cap, {7'h2B, 1'b0, 8'h5E}); end
    n_chk++; if (cs_after != 0) begin n_fail++; $display("FAIL busy_no_requeue got %0d want 0", cs_after); end
  endtask

  task automatic test_reset_mid;
    int n, dones, lat;
    cur_rbyte = 8'h99;
    @(negedge clk);
    addr = 7'h41; rw = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rise_cnt != 7 && n < 2000) begin @(negedge clk); n++; end
    n_chk++; if (n >= 2000) begin n_fail++; $display("FAIL rstmid_wait got timeout want sclk edge 7"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_chk++; if ({cs_pin, sclk_pin, mosi_pin, busy, done} !== 5'b10000)
      begin n_fail++; $display("FAIL rstmid_pins cs,sclk,mosi,busy,done=%b want 10000", {cs_pin, sclk_pin, mosi_pin, busy, done}); end
    n_chk++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL rstmid_rdata got %h want 00", rdata); end
    exp_rdata = 8'h00;
    dones = 0;
    repeat (LAT) begin if (done || !cs_pin) dones++; @(negedge clk); end
    n_chk++; if (dones != 0) begin n_fail++; $display("FAIL rstmid_quiet got %0d want 0", dones); end
    run_frame(7'h66, 1'b0, 8'hC3, 8'h00, lat);
    n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL rstmid_next_lat got %0d want %0d", lat, LAT); end
    n_chk++; if (mosi_cap !== {7'h66, 1'b0, 8'hC3}) begin n_fail++; $display("FAIL rstmid_next_mosi got %h want %h", mosi_cap, {7'h66, 1'b0, 8'hC3}); end
  endtask

  task automatic test_start_reset;
    @(negedge clk);
    addr = 7'h11; rw = 1'b0; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({busy, cs_pin} !== 2'b01) begin n_fail++; $display("FAIL start_reset busy,cs=%b want 01", {busy, cs_pin}); end
  endtask

  task automatic test_random;
    int lat;
    logic [6:0] a; logic r; logic [7:0] w, rb;
    for (int i = 0; i < 16; i++) begin
      a = 7'($urandom); r = 1'($urandom); w = 8'($urandom); rb = 8'($urandom);
      run_frame(a, r, w, rb, lat);
      if (r) exp_rdata = rb;
      n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, LAT); end
      n_chk++; if (mosi_cap !== {a, r, r ? 8'h00 : w}) begin n_fail++; $display("FAIL rnd%0d_mosi got %h want %h", i, mosi_cap, {a, r, r ? 8'h00 : w}); end
      n_chk++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd%0d_rdata got %h want %h", i, rdata, exp_rdata); end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy_ignore();
    test_reset_mid();
    test_start_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
